instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Purpose: instruction fetch stage. Issues one memory read per instruction, holds the word in IR until decode takes it.
// Latency: IDLE->FETCH takes 1 cycle; IR/IR_valid update on the MemAck edge; PC_enable fires combinationally in the MemAck cycle.
// Backpressure: DecodeReady=0 parks the unit in HOLD with MemReq=0, so no new fetch starts until IR is consumed.
module instruction_fetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        IF_Reset,
    input  logic        Run,
    input  logic [31:0] PC,
    input  logic        Flush,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    input  logic        DecodeReady,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic        PC_enable,
    output logic [31:0] IR,
    output logic [31:0] IR_PC,
    output logic        IR_valid,
    output logic [31:0] BranchOff,
    output logic [15:0] FetchCount,
    output logic        Fault
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Last wait-count value before a missing MemAck becomes a fault.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,       state_d;
    logic [31:0] mem_addr_q,    mem_addr_d;
    logic [31:0] ir_q,          ir_d;
    logic [31:0] ir_pc_q,       ir_pc_d;
    logic        ir_valid_q,    ir_valid_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [7:0]  wait_cnt_q,    wait_cnt_d;
    logic        fault_q,       fault_d;

    // A fetch completes only when memory answers and no flush discards the word.
    logic ack_take;

    // Qualify the returning word: flush wins over MemAck.
    always_comb begin
        ack_take = (state_q == ST_FETCH) && MemAck && !Flush;
    end

    // Next-state and datapath loads for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;
        wait_cnt_d    = wait_cnt_q;
        fault_d       = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (Run && !Flush) begin
                    state_d    = ST_FETCH;
                    mem_addr_d = PC;
                    wait_cnt_d = 8'd0;
                end
            end

            ST_FETCH: begin
                if (Flush) begin
                    // Abandon the request; the returning word, if any, is dropped.
                    state_d    = ST_IDLE;
                    ir_valid_d = 1'b0;
                end else if (MemAck) begin
                    state_d       = ST_HOLD;
                    ir_d          = MemData;
                    ir_pc_d       = mem_addr_q;
                    ir_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 16'd1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            ST_HOLD: begin
                if (Flush) begin
                    state_d    = ST_IDLE;
                    ir_valid_d = 1'b0;
                end else if (DecodeReady) begin
                    ir_valid_d = 1'b0;
                    if (Run) begin
                        // PC already advanced on the PC_enable edge, so it is the next address.
                        state_d    = ST_FETCH;
                        mem_addr_d = PC;
                        wait_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_FAULT: begin
                // Sticky until reset: Run, Flush and MemAck have no effect here.
                ir_valid_d = 1'b0;
                fault_d    = 1'b1;
            end

            default: begin
                state_d    = ST_IDLE;
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over every input.
    always_ff @(posedge Clock) begin
        if (IF_Reset) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= 32'd0;
            ir_q          <= 32'd0;
            ir_pc_q       <= 32'd0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= 16'd0;
            wait_cnt_q    <= 8'd0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
        end
    end

    // Output drive: request follows FETCH, PC strobe is suppressed while reset is held.
    always_comb begin
        MemReq     = (state_q == ST_FETCH);
        MemAddr    = mem_addr_q;
        PC_enable  = ack_take && !IF_Reset;
        IR         = ir_q;
        IR_PC      = ir_pc_q;
        IR_valid   = ir_valid_q;
        BranchOff  = {{16{ir_q[15]}}, ir_q[15:0]};
        FetchCount = fetch_count_q;
        Fault      = fault_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose: self-checking bench for instruction_fetch_unit (vector table, corner sequences, random vs reference model).
// Latency: inputs driven on the falling edge, outputs sampled 1-2 time units later, well before the rising edge.
// Backpressure: DecodeReady is driven directly by the stimulus.
module tb_instruction_fetch_unit;

    localparam int TO = 4;

    logic        Clock = 1'b0;
    logic        IF_Reset, Run, Flush, MemAck, DecodeReady;
    logic [31:0] PC, MemData;
    logic        MemReq, PC_enable, IR_valid, Fault;
    logic [31:0] MemAddr, IR, IR_PC, BranchOff;
    logic [15:0] FetchCount;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.TIMEOUT(TO)) dut (
        .Clock(Clock), .IF_Reset(IF_Reset), .Run(Run), .PC(PC), .Flush(Flush),
        .MemAck(MemAck), .MemData(MemData), .DecodeReady(DecodeReady),
        .MemReq(MemReq), .MemAddr(MemAddr), .PC_enable(PC_enable), .IR(IR),
        .IR_PC(IR_PC), .IR_valid(IR_valid), .BranchOff(BranchOff),
        .FetchCount(FetchCount), .Fault(Fault)
    );

    always #5 Clock = ~Clock;

    // Reference model: a request is outstanding, an instruction is held, or the unit has faulted.
    bit          m_busy, m_have, m_fault;
    int          m_waited;
    logic [31:0] m_addr, m_ir, m_irpc;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_have = 0; m_fault = 0; m_waited = 0;
        m_addr = 0; m_ir = 0; m_irpc = 0; m_cnt = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        if (IF_Reset) begin
            model_reset();
        end else if (m_fault) begin
            // nothing leaves the fault condition except reset
        end else if (Flush) begin
            m_busy = 0;
            m_have = 0;
        end else if (m_busy) begin
            if (MemAck) begin
                m_ir   = MemData;
                m_irpc = m_addr;
                m_have = 1;
                m_busy = 0;
                m_cnt  = m_cnt + 16'd1;
            end else if (m_waited == TO - 1) begin
                m_fault = 1;
                m_busy  = 0;
            end else begin
                m_waited++;
            end
        end else if (m_have) begin
            if (DecodeReady) begin
                m_have = 0;
                if (Run) begin
                    m_busy = 1; m_addr = PC; m_waited = 0;
                end
            end
        end else if (Run) begin
            m_busy = 1; m_addr = PC; m_waited = 0;
        end
    endtask

    // Compare every output against the model, then clock once.
    task automatic cycle();
        logic [31:0] sext;
        #1;
        sext = m_ir[15] ? {16'hFFFF, m_ir[15:0]} : {16'h0000, m_ir[15:0]};
        chk("MemReq",     {31'd0, MemReq},    {31'd0, m_busy});
        chk("PC_enable",  {31'd0, PC_enable}, {31'd0, m_busy && MemAck && !Flush && !IF_Reset && !m_fault});
        chk("IR_valid",   {31'd0, IR_valid},  {31'd0, m_have});
        chk("Fault",      {31'd0, Fault},     {31'd0, m_fault});
        chk("MemAddr",    MemAddr,            m_addr);
        chk("IR",         IR,                 m_ir);
        chk("IR_PC",      IR_PC,              m_irpc);
        chk("BranchOff",  BranchOff,          sext);
        chk("FetchCount", {16'd0, FetchCount}, {16'd0, m_cnt});
        model_step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic drive(input logic rst, input logic run, input logic flush, input logic ack,
                         input logic dr, input logic [31:0] pc, input logic [31:0] data);
        IF_Reset = rst; Run = run; Flush = flush; MemAck = ack;
        DecodeReady = dr; PC = pc; MemData = data;
    endtask

    typedef struct {
        logic        rst, run, flush, ack, dr;
        logic [31:0] pc, data;
        logic        memreq, pcen, irv, fault;
        logic [31:0] addr, ir;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mkv(logic rst, logic run, logic flush, logic ack, logic dr,
                                 logic [31:0] pc, logic [31:0] data,
                                 logic memreq, logic pcen, logic irv, logic fault,
                                 logic [31:0] addr, logic [31:0] ir, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.run = run; v.flush = flush; v.ack = ack; v.dr = dr;
        v.pc = pc; v.data = data; v.memreq = memreq; v.pcen = pcen; v.irv = irv;
        v.fault = fault; v.addr = addr; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    vec_t vecs[11];

    initial begin
        // Fetch at 0x10, hold for 5 cycles with decode stalled, release, then flush with MemAck.
        //               rst run fl ack dr  pc          data          req pce irv flt addr        ir            cnt
        vecs[0]  = mkv(0, 1, 0, 0, 0, 32'h10, 32'h0,        0, 0, 0, 0, 32'h0,  32'h0,        16'd0);
        vecs[1]  = mkv(0, 1, 0, 0, 0, 32'h10, 32'h0,        1, 0, 0, 0, 32'h10, 32'h0,        16'd0);
        vecs[2]  = mkv(0, 1, 0, 1, 0, 32'h10, 32'h8C01FFFE, 1, 1, 0, 0, 32'h10, 32'h0,        16'd0);
        for (int i = 3; i < 8; i++)
            vecs[i] = mkv(0, 1, 0, 1, 0, 32'h14, 32'hFFFFFFFF, 0, 0, 1, 0, 32'h10, 32'h8C01FFFE, 16'd1);
        vecs[8]  = mkv(0, 1, 0, 0, 1, 32'h14, 32'h0,        0, 0, 1, 0, 32'h10, 32'h8C01FFFE, 16'd1);
        vecs[9]  = mkv(0, 1, 1, 1, 0, 32'h14, 32'h12345678, 1, 0, 0, 0, 32'h14, 32'h8C01FFFE, 16'd1);
        vecs[10] = mkv(0, 0, 0, 0, 0, 32'h18, 32'h0,        0, 0, 0, 0, 32'h14, 32'h8C01FFFE, 16'd1);

        // Initial reset; state is unknown before the first edge so nothing is compared yet.
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].flush, vecs[i].ack, vecs[i].dr, vecs[i].pc, vecs[i].data);
            #1;
            chk($sformatf("vec%0d MemReq", i),     {31'd0, MemReq},    {31'd0, vecs[i].memreq});
            chk($sformatf("vec%0d PC_enable", i),  {31'd0, PC_enable}, {31'd0, vecs[i].pcen});
            chk($sformatf("vec%0d IR_valid", i),   {31'd0, IR_valid},  {31'd0, vecs[i].irv});
            chk($sformatf("vec%0d Fault", i),      {31'd0, Fault},     {31'd0, vecs[i].fault});
            chk($sformatf("vec%0d MemAddr", i),    MemAddr,            vecs[i].addr);
            chk($sformatf("vec%0d IR", i),         IR,                 vecs[i].ir);
            chk($sformatf("vec%0d FetchCount", i), {16'd0, FetchCount}, {16'd0, vecs[i].cnt});
            if (i == 4) begin
                chk("vec BranchOff", BranchOff, 32'hFFFFFFFE);
                chk("vec IR_PC", IR_PC, 32'h10);
            end
            cycle();
        end

        // FetchCount wrap: park the counter at 16'hFFFF while idle, then complete one fetch.
        drive(0, 0, 0, 0, 0, 32'h40, 32'h0);
        force dut.fetch_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        cycle();
        release dut.fetch_count_q;
        drive(0, 1, 0, 0, 0, 32'h40, 32'h0);
        cycle();
        drive(0, 1, 0, 1, 0, 32'h40, 32'hDEAD0001);
        cycle();
        drive(0, 0, 0, 0, 1, 32'h44, 32'h0);
        #1;
        chk("wrap FetchCount", {16'd0, FetchCount}, 32'd0);
        chk("wrap IR", IR, 32'hDEAD0001);
        cycle();

        // Timeout: four FETCH cycles without MemAck, then sticky fault.
        drive(0, 1, 0, 0, 0, 32'h80, 32'h0);
        cycle();
        for (int k = 0; k < TO; k++) begin
            drive(0, 1, 0, 0, 0, 32'h84, 32'h0);
            #1;
            chk("timeout pre Fault", {31'd0, Fault}, 32'd0);
            chk("timeout MemReq", {31'd0, MemReq}, 32'd1);
            cycle();
        end
        for (int k = 0; k < 6; k++) begin
            drive(0, k[0], k[1], 1'b1, 1'b1, 32'h90, 32'h55AA55AA);
            #1;
            chk("fault sticky", {31'd0, Fault}, 32'd1);
            chk("fault PC_enable", {31'd0, PC_enable}, 32'd0);
            cycle();
        end
        drive(1, 1, 0, 1, 0, 32'h0, 32'h0);
        cycle();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("fault cleared", {31'd0, Fault}, 32'd0);
        cycle();

        // Reset arriving mid-fetch together with MemAck, then a stray MemAck afterwards.
        drive(0, 1, 0, 0, 0, 32'h100, 32'h0);
        cycle();
        drive(1, 1, 0, 1, 0, 32'h104, 32'hCAFEBABE);
        #1;
        chk("rst PC_enable", {31'd0, PC_enable}, 32'd0);
        cycle();
        drive(0, 0, 0, 1, 1, 32'h108, 32'h11112222);
        #1;
        chk("rst MemReq", {31'd0, MemReq}, 32'd0);
        chk("rst MemAddr", MemAddr, 32'd0);
        chk("rst IR", IR, 32'd0);
        chk("rst FetchCount", {16'd0, FetchCount}, 32'd0);
        cycle();
        drive(0, 0, 0, 1, 1, 32'h10C, 32'h33334444);
        #1;
        chk("stray ack IR_valid", {31'd0, IR_valid}, 32'd0);
        chk("stray ack IR", IR, 32'd0);
        cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom, $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
